fpu_seq: RTL and testbench

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_pkg.sv | 57 +++++
 rtl/fpu_seq_fcmp.sv | 42 ++++
 rtl/fpu_seq.sv | 99 +++++++++
 tb/tb_fpu_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared op-code, latency and compare-select definitions for the sequenced FPU front end.
package fpu_pkg;

    typedef enum logic [3:0] {
        OP_FADD  = 4'b0000,
        OP_FSUB  = 4'b0001,
        OP_FMUL  = 4'b0010,
        OP_FDIV  = 4'b0011,
        OP_FSQRT = 4'b0100,
        OP_FTOI  = 4'b0101,
        OP_FEQ   = 4'b0110,
        OP_FLT   = 4'b0111,
        OP_FLE   = 4'b1000,
        OP_ITOF  = 4'b1001
    } fpu_op_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_LE = 2'b10
    } cmp_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int LAT_ARITH = 2;
    localparam int LAT_LONG  = 4;
    localparam int LAT_SHORT = 1;

    // Counter preload is L-1 so the done cycle lands exactly L cycles after accept.
    function automatic logic [1:0] op_count(input logic [3:0] op);
        case (op)
            OP_FADD, OP_FSUB, OP_FMUL: op_count = 2'(LAT_ARITH - 1);
            OP_FDIV, OP_FSQRT:         op_count = 2'(LAT_LONG - 1);
            default:                   op_count = 2'(LAT_SHORT - 1);
        endcase
    endfunction

    function automatic logic is_cmp(input logic [3:0] op);
        is_cmp = (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE);
    endfunction

    function automatic logic is_valid(input logic [3:0] op);
        is_valid = (op <= 4'(OP_ITOF));
    endfunction

    function automatic cmp_op_e cmp_sel(input logic [3:0] op);
        case (op)
            OP_FLT:  cmp_sel = CMP_LT;
            OP_FLE:  cmp_sel = CMP_LE;
            default: cmp_sel = CMP_EQ;
        endcase
    endfunction

endpackage

// File: rtl/fpu_seq_fcmp.sv
// Single-precision compare on sign-magnitude ordering; +0 and -0 compare equal, NaN bits are not special.
module fcmp
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic        y
);

    logic both_zero;
    logic eq;
    logic lt;

    assign both_zero = (a[30:0] == 31'h0) && (b[30:0] == 31'h0);
    assign eq        = (a == b) || both_zero;

    // Negative values order by descending magnitude, positive by ascending.
    always_comb begin
        lt = 1'b0;
        if (both_zero) begin
            lt = 1'b0;
        end else if (a[31] != b[31]) begin
            lt = a[31];
        end else if (!a[31]) begin
            lt = (a[30:0] < b[30:0]);
        end else begin
            lt = (a[30:0] > b[30:0]);
        end
    end

    always_comb begin
        y = 1'b0;
        case (op)
            CMP_EQ:  y = eq;
            CMP_LT:  y = lt;
            CMP_LE:  y = lt || eq;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_seq.sv
// Single-outstanding FPU sequencer: latches an op, counts its fixed latency, and presents the result for one cycle.
module fpu_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [3:0]  fpucontrol,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mode,
    input  logic        fregwb,
    output logic        ready,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic        wbint,
    output logic [3:0]  uop,
    output logic [31:0] ua,
    output logic [31:0] ub,
    output logic        umode,
    input  logic [31:0] fres
);

    state_e     state;
    state_e     state_next;
    logic [1:0] cnt;
    logic       cmp_q;
    logic       cmp_now;
    logic       accept;

    fcmp u_fcmp (
        .a  (srca),
        .b  (srcb),
        .op (cmp_sel(fpucontrol)),
        .y  (cmp_now)
    );

    assign accept = (state == S_IDLE) && req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            uop   <= 4'h0;
            ua    <= 32'h0;
            ub    <= 32'h0;
            umode <= 1'b0;
            wbint <= 1'b0;
            cmp_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= op_count(fpucontrol);
                uop   <= fpucontrol;
                ua    <= srca;
                ub    <= srcb;
                umode <= mode;
                wbint <= fregwb;
                cmp_q <= cmp_now;
            end else if ((state == S_BUSY) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // req is deliberately not looked at in BUSY, so a request in the done cycle waits for IDLE.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        stall      = 1'b0;
        result     = 32'h0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                stall = rst_n && req;
                if (req) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 2'd0) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                    if (is_cmp(uop)) begin
                        result = {31'h0, cmp_q};
                    end else if (is_valid(uop)) begin
                        result = fres;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq: directed scenarios plus random ops against a value-ordering reference model.
module tb_fpu_seq;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  fpucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mode;
    logic        fregwb;
    logic        ready;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        wbint;
    logic [3:0]  uop;
    logic [31:0] ua;
    logic [31:0] ub;
    logic        umode;
    logic [31:0] fres;

    typedef struct {
        logic [31:0] res;
        logic        wb;
        logic        md;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          start;
    } exp_t;

    exp_t sbq[$];
    int   total;
    int   passed;
    int   cyc;
    int   done_seen;

    fpu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .fpucontrol (fpucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .mode       (mode),
        .fregwb     (fregwb),
        .ready      (ready),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .wbint      (wbint),
        .uop        (uop),
        .ua         (ua),
        .ub         (ub),
        .umode      (umode),
        .fres       (fres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2: lat_of = 2;
            4'd3, 4'd4:       lat_of = 4;
            default:          lat_of = 1;
        endcase
    endfunction

    // Map a float bit pattern onto a signed integer with the same ordering (-0 becomes 0).
    function automatic longint key(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        key = x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] fv);
        case (op)
            4'd6:    model = (key(a) == key(b)) ? 32'h1 : 32'h0;
            4'd7:    model = (key(a) <  key(b)) ? 32'h1 : 32'h0;
            4'd8:    model = (key(a) <= key(b)) ? 32'h1 : 32'h0;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9: model = fv;
            default: model = 32'h0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic md, input logic wb, input logic [31:0] fv, input bit hold);
        exp_t e;
        @(posedge clk);
        #1;
        fpucontrol = op;
        srca       = a;
        srcb       = b;
        mode       = md;
        fregwb     = wb;
        fres       = fv;
        req        = 1'b1;
        @(negedge clk);
        checkOutput("cyc0_stall", {31'h0, stall}, 32'h1);
        checkOutput("cyc0_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        #1;
        e.res   = model(op, a, b, fv);
        e.wb    = wb;
        e.md    = md;
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.lat   = lat_of(op);
        e.start = cyc;
        sbq.push_back(e);
        if (!hold) req = 1'b0;
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        if (!seen) checkOutput("idle_timeout", 32'h0, 32'h1);
    endtask

    // Monitor: pops the scoreboard on every done pulse and watches the held operands while busy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    done_seen++;
                    checkOutput("result",  result, e.res);
                    checkOutput("wbint",   {31'h0, wbint}, {31'h0, e.wb});
                    checkOutput("umode",   {31'h0, umode}, {31'h0, e.md});
                    checkOutput("uop",     {28'h0, uop}, {28'h0, e.op});
                    checkOutput("latency", 32'(cyc - e.start + 1), 32'(e.lat));
                    checkOutput("done_stall", {31'h0, stall}, 32'h0);
                end
            end else if (!ready && sbq.size() != 0) begin
                checkOutput("busy_result", result, 32'h0);
                checkOutput("busy_ua", ua, sbq[0].a);
                checkOutput("busy_ub", ub, sbq[0].b);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int d0;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        total      = 0;
        passed     = 0;
        done_seen  = 0;
        rst_n      = 1'b0;
        req        = 1'b0;
        fpucontrol = 4'h0;
        srca       = 32'h0;
        srcb       = 32'h0;
        mode       = 1'b0;
        fregwb     = 1'b0;
        fres       = 32'h0;
        #12;
        checkOutput("rst_ready", {31'h0, ready}, 32'h1);
        checkOutput("rst_done",  {31'h0, done}, 32'h0);
        checkOutput("rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_ua", ua, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fadd latency 2");
        applyStimulus(4'd0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 1'b0);
        @(negedge clk);
        checkOutput("fadd_c1_stall", {31'h0, stall}, 32'h1);
        checkOutput("fadd_c1_done",  {31'h0, done}, 32'h0);
        @(negedge clk);
        checkOutput("fadd_c2_done",  {31'h0, done}, 32'h1);
        checkOutput("fadd_c2_result", result, 32'h40400000);
        @(negedge clk);
        checkOutput("fadd_c3_done",  {31'h0, done}, 32'h0);
        checkOutput("fadd_c3_ready", {31'h0, ready}, 32'h1);

        $display("[TB] compares and invalid op");
        waitIdle();
        applyStimulus(4'd7, 32'hBF800000, 32'h3F800000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        waitIdle();
        applyStimulus(4'd6, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 32'h12345678, 1'b0);
        waitIdle();
        applyStimulus(4'd8, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h12345678, 1'b0);
        waitIdle();
        applyStimulus(4'hF, 32'h40000000, 32'h3F800000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        waitIdle();

        $display("[TB] fdiv with req held");
        d0 = done_seen;
        applyStimulus(4'd3, 32'h41200000, 32'h40000000, 1'b0, 1'b0, 32'h40A00000, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("fdiv_ready", {31'h0, ready}, 32'h0);
            checkOutput("fdiv_ua", ua, 32'h41200000);
            checkOutput("fdiv_ub", ub, 32'h40000000);
            if (i < 4) checkOutput("fdiv_stall", {31'h0, stall}, 32'h1);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("fdiv_c5_ready", {31'h0, ready}, 32'h1);
        checkOutput("fdiv_done_count", 32'(done_seen - d0), 32'h1);

        $display("[TB] reset during fsqrt");
        waitIdle();
        applyStimulus(4'd4, 32'h40800000, 32'h0, 1'b1, 1'b1, 32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 1'b1;
        sbq.delete();
        d0 = done_seen;
        #1;
        checkOutput("mid_rst_done",  {31'h0, done}, 32'h0);
        checkOutput("mid_rst_ready", {31'h0, ready}, 32'h1);
        checkOutput("mid_rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("mid_rst_result", result, 32'h0);
        checkOutput("mid_rst_wbint", {31'h0, wbint}, 32'h0);
        checkOutput("mid_rst_uop", {28'h0, uop}, 32'h0);
        checkOutput("mid_rst_ua", ua, 32'h0);
        checkOutput("mid_rst_ub", ub, 32'h0);
        checkOutput("mid_rst_umode", {31'h0, umode}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("no_done_after_rst", 32'(done_seen - d0), 32'h0);
        applyStimulus(4'd9, 32'h00000007, 32'h0, 1'b0, 1'b0, 32'h40E00000, 1'b0);
        waitIdle();

        $display("[TB] random ops");
        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = ra;
                1:       rb = ra ^ 32'h80000000;
                2:       begin ra = {ra[31], 31'h0}; rb = {~ra[31], 31'h0}; end
                3:       rb = {~ra[31], ra[30:0] + 31'($urandom_range(0, 3))};
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            waitIdle();
        end

        checkOutput("sb_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
